// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the 3x3 Sobel window path: default frame geometry
// limits, counter width and the window sequencer state encoding. The same
// defaults size the line buffer, so both sides agree on MAX_WIDTH.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int SOBEL_MAX_WIDTH  = 2100;  // max active pixels per line
    localparam int SOBEL_MAX_HEIGHT = 2100;  // max active lines per frame
    localparam int SOBEL_CNT_W      = 12;    // 2**12 > 2100

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LINE = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;
    localparam logic [1:0] ST_BLANK     = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WAIT_LINE = ST_WAIT_LINE,
        ACTIVE    = ST_ACTIVE,
        BLANK     = ST_BLANK
    } sobel_state_t;

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl_if
// Bundles the raw video timing inputs and the window/measurement outputs of
// sobel_window_ctrl.
//   master: drives enable/hsync/vsync/de, observes window and frame status.
//   slave : the sequencer (sobel_window_ctrl).
// Signals: enable, hsync, vsync, de (timing in); win_valid, win_x, win_y,
//   frame_start, frame_done, meas_width, meas_height, fmt_err (status out);
//   frame_cnt, err_cnt only when SOBEL_WCTRL_STATS_EN is defined.
// -----------------------------------------------------------------------------
interface sobel_window_ctrl_if #(
    parameter int CNT_W = sobel_pkg::SOBEL_CNT_W
);
    logic             enable;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             win_valid;
    logic [CNT_W-1:0] win_x;
    logic [CNT_W-1:0] win_y;
    logic             frame_start;
    logic             frame_done;
    logic [CNT_W-1:0] meas_width;
    logic [CNT_W-1:0] meas_height;
    logic             fmt_err;
`ifdef SOBEL_WCTRL_STATS_EN
    logic [15:0]      frame_cnt;
    logic [15:0]      err_cnt;
`endif

    modport master (
        output enable, hsync, vsync, de,
        input  win_valid, win_x, win_y, frame_start, frame_done,
               meas_width, meas_height, fmt_err
`ifdef SOBEL_WCTRL_STATS_EN
        , input frame_cnt, err_cnt
`endif
    );

    modport slave (
        input  enable, hsync, vsync, de,
        output win_valid, win_x, win_y, frame_start, frame_done,
               meas_width, meas_height, fmt_err
`ifdef SOBEL_WCTRL_STATS_EN
        , output frame_cnt, err_cnt
`endif
    );

endinterface

// File: rtl/sobel_edge_det.sv
// -----------------------------------------------------------------------------
// sobel_edge_det
// Registers one input and reports its edges against the registered copy.
// Ports: clk, rst (async, active high), sig (input), rise = sig & ~sig_q,
//   fall = ~sig & sig_q (both combinational from the live input).
// -----------------------------------------------------------------------------
module sobel_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
// Frame/line sequencer for the 3x3 Sobel window. Tracks the input row/column
// of the raw video stream feeding the line buffer, flags cycles where the
// window centre sits on a pixel with a full 3x3 neighbourhood, measures frame
// geometry and reports format errors.
// Ports:
//   clk, rst    pixel clock, asynchronous active-high reset
//   bus (slave) enable/hsync/vsync/de in; win_valid, win_x, win_y,
//               frame_start, frame_done, meas_width, meas_height, fmt_err out
// Optional: define SOBEL_WCTRL_STATS_EN to add frame_cnt (wrapping count of
//   frame_done) and err_cnt (saturating count of fmt_err rising edges).
// -----------------------------------------------------------------------------
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int MAX_WIDTH  = SOBEL_MAX_WIDTH,
    parameter int MAX_HEIGHT = SOBEL_MAX_HEIGHT,
    parameter int CNT_W      = SOBEL_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    sobel_window_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_W_C = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] MAX_H_C = CNT_W'(MAX_HEIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    // Edge detectors on the raw timing inputs
    logic vs_rise, vs_fall;
    logic hs_rise, hs_fall;
    logic de_rise, de_fall;

    sobel_edge_det u_vs_det (.clk(clk), .rst(rst), .sig(bus.vsync), .rise(vs_rise), .fall(vs_fall));
    sobel_edge_det u_hs_det (.clk(clk), .rst(rst), .sig(bus.hsync), .rise(hs_rise), .fall(hs_fall));
    sobel_edge_det u_de_det (.clk(clk), .rst(rst), .sig(bus.de),    .rise(de_rise), .fall(de_fall));

    // hsync only confirms line boundaries that de already defines; a line
    // without an hsync edge is legal, so no decision depends on these edges.
    logic unused_edges;
    assign unused_edges = ^{vs_fall, hs_rise, hs_fall, de_rise};

    // Registered state
    sobel_state_t     state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;          // lines completed in this frame
    logic [CNT_W-1:0] col_q, col_d;          // pixels seen in current line
    logic [CNT_W-1:0] first_w_q, first_w_d;  // width of the first line
    logic             first_ok_q, first_ok_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_x_q, win_x_d;
    logic [CNT_W-1:0] win_y_q, win_y_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] meas_w_q, meas_w_d;
    logic [CNT_W-1:0] meas_h_q, meas_h_d;
    logic             fmt_err_q, fmt_err_d;

    // Helper terms
    logic [CNT_W-1:0] pix_col;   // column index of a pixel arriving now
    logic             open_line; // a line is still in progress
    logic [CNT_W-1:0] line_h;    // frame height counting an open line
    logic [CNT_W-1:0] line_w;    // first-line width, open line if unfinished

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            first_w_q     <= '0;
            first_ok_q    <= 1'b0;
            win_valid_q   <= 1'b0;
            win_x_q       <= '0;
            win_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            meas_w_q      <= '0;
            meas_h_q      <= '0;
            fmt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            first_w_q     <= first_w_d;
            first_ok_q    <= first_ok_d;
            win_valid_q   <= win_valid_d;
            win_x_q       <= win_x_d;
            win_y_q       <= win_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            meas_w_q      <= meas_w_d;
            meas_h_q      <= meas_h_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

    // NOTE: every variable written here is given a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        first_w_d     = first_w_q;
        first_ok_d    = first_ok_q;
        win_valid_d   = 1'b0;
        win_x_d       = win_x_q;
        win_y_d       = win_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        meas_w_d      = meas_w_q;
        meas_h_d      = meas_h_q;
        fmt_err_d     = fmt_err_q;

        open_line = (state_q == ACTIVE);
        pix_col   = open_line ? col_q : '0;
        line_h    = (open_line && (row_q < MAX_H_C)) ? row_q + ONE : row_q;
        line_w    = first_ok_q ? first_w_q : (open_line ? col_q : '0);

        if (!bus.enable) begin
            state_d = IDLE;
        end else if (vs_rise) begin
            // Frame start wins over any pixel or line end on the same cycle.
            // Measurements only latch if the closing frame had a line, so
            // meas_* always describes a frame that actually carried data.
            if ((state_q != IDLE) && ((row_q != '0) || open_line)) begin
                frame_done_d = 1'b1;
                meas_w_d     = line_w;
                meas_h_d     = line_h;
            end
            frame_start_d = 1'b1;
            fmt_err_d     = 1'b0;
            row_d         = '0;
            first_w_d     = '0;
            first_ok_d    = 1'b0;
            if (bus.de) begin
                state_d = ACTIVE;   // this pixel is (row 0, col 0)
                col_d   = ONE;
            end else begin
                state_d = WAIT_LINE;
                col_d   = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WAIT_LINE, BLANK, ACTIVE: begin
                    if (bus.de) begin
                        state_d = ACTIVE;
                        // A pixel arriving with col already at MAX_WIDTH is one
                        // past the legal line: col saturates and it never
                        // produces a window. Same for rows past MAX_HEIGHT.
                        if (pix_col < MAX_W_C) begin
                            col_d = pix_col + ONE;
                        end else begin
                            col_d     = pix_col;
                            fmt_err_d = 1'b1;
                        end
                        if (row_q >= MAX_H_C) begin
                            fmt_err_d = 1'b1;
                        end
                        // Line buffer centre lags the input by one row and one
                        // column, so the window is complete once r,c >= 2.
                        if ((row_q >= TWO) && (pix_col >= TWO) &&
                            (pix_col < MAX_W_C) && (row_q < MAX_H_C)) begin
                            win_valid_d = 1'b1;
                            win_x_d     = pix_col - ONE;
                            win_y_d     = row_q - ONE;
                        end
                    end else if (open_line && de_fall) begin
                        state_d = BLANK;
                        col_d   = '0;
                        if (row_q < MAX_H_C) begin
                            row_d = row_q + ONE;
                        end
                        if (!first_ok_q) begin
                            first_ok_d = 1'b1;
                            first_w_d  = col_q;
                        end else if (col_q != first_w_q) begin
                            fmt_err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.win_valid   = win_valid_q;
    assign bus.win_x       = win_x_q;
    assign bus.win_y       = win_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.meas_width  = meas_w_q;
    assign bus.meas_height = meas_h_q;
    assign bus.fmt_err     = fmt_err_q;

`ifdef SOBEL_WCTRL_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // Counters advance with the same edge that raises frame_done / fmt_err,
    // and survive frame starts; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (fmt_err_d && !fmt_err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_ctrl
// Directed bench for sobel_window_ctrl: drives hand-built video frames through
// the interface and compares window coordinates, frame pulses, measurements
// and format errors against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sobel_window_ctrl;

    localparam int CNT_W = 12;

    logic clk;
    logic rst;

    sobel_window_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sobel_window_ctrl #(
        .MAX_WIDTH (2100),
        .MAX_HEIGHT(2100),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed windows and pulses, collected one sample per cycle
    int wx_q[$];
    int wy_q[$];
    int ex_q[$];
    int ey_q[$];
    int fs_cnt;
    int max_x;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        wx_q.delete();
        wy_q.delete();
        ex_q.delete();
        ey_q.delete();
        fs_cnt = 0;
        max_x  = 0;
    endtask

    // One pixel-clock cycle: drive inputs, step past the edge, sample outputs
    task automatic cycle(input logic v, input logic h, input logic d);
        bus.vsync = v;
        bus.hsync = h;
        bus.de    = d;
        @(posedge clk);
        #1;
        if (bus.win_valid) begin
            wx_q.push_back(int'(bus.win_x));
            wy_q.push_back(int'(bus.win_y));
            if (int'(bus.win_x) > max_x) max_x = int'(bus.win_x);
        end
        if (bus.frame_start) fs_cnt++;
    endtask

    task automatic line(input int w);
        for (int p = 0; p < w; p++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    // Expected window row: centre row y, centres x = 1..xmax
    task automatic add_row(input int y, input int xmax);
        for (int x = 1; x <= xmax; x++) begin
            ex_q.push_back(x);
            ey_q.push_back(y);
        end
    endtask

    task automatic check_windows(input string tag);
        check({tag, "_count"}, wx_q.size(), ex_q.size());
        for (int i = 0; i < ex_q.size() && i < wx_q.size(); i++) begin
            check($sformatf("%s_x%0d", tag, i), wx_q[i], ex_q[i]);
            check($sformatf("%s_y%0d", tag, i), wy_q[i], ey_q[i]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.vsync  = 1'b0;
        bus.hsync  = 1'b0;
        bus.de     = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state ----
        check("rst_win_valid",   int'(bus.win_valid),   0);
        check("rst_win_x",       int'(bus.win_x),       0);
        check("rst_win_y",       int'(bus.win_y),       0);
        check("rst_frame_start", int'(bus.frame_start), 0);
        check("rst_frame_done",  int'(bus.frame_done),  0);
        check("rst_meas_width",  int'(bus.meas_width),  0);
        check("rst_meas_height", int'(bus.meas_height), 0);
        check("rst_fmt_err",     int'(bus.fmt_err),     0);
        rst        = 1'b0;
        bus.enable = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // ---- frame A: clean 5x4 ----
        vs_pulse();
        check("a_frame_start", int'(bus.frame_start), 1);
        check("a_frame_done",  int'(bus.frame_done),  0);
        clear_obs();
        for (int l = 0; l < 4; l++) line(5);
        add_row(1, 3);
        add_row(2, 3);
        check_windows("a_win");
        check("a_fmt_err", int'(bus.fmt_err), 0);

        // ---- frame B: line 2 is 4 wide ----
        vs_pulse();
        check("b_frame_done",  int'(bus.frame_done),  1);
        check("b_frame_start", int'(bus.frame_start), 1);
        check("b_meas_width",  int'(bus.meas_width),  5);
        check("b_meas_height", int'(bus.meas_height), 4);
        check("b_fmt_err0",    int'(bus.fmt_err),     0);
        clear_obs();
        line(5);
        line(5);
        check("b_err_before_short", int'(bus.fmt_err), 0);
        line(4);
        check("b_err_after_short", int'(bus.fmt_err), 1);
        line(5);
        check("b_err_sticky", int'(bus.fmt_err), 1);
        add_row(1, 2);
        add_row(2, 3);
        check_windows("b_win");
        vs_pulse();
        check("b_end_frame_done", int'(bus.frame_done), 1);
        check("b_end_fmt_clear",  int'(bus.fmt_err),    0);
        check("b_end_meas_h",     int'(bus.meas_height), 4);

        // ---- frame C: vsync rises together with the first pixel ----
        cycle(1'b0, 1'b0, 1'b0);
        clear_obs();
        cycle(1'b1, 1'b0, 1'b1);
        check("c_frame_start", int'(bus.frame_start), 1);
        check("c_no_done",     int'(bus.frame_done),  0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) line(5);
        add_row(1, 3);
        add_row(2, 3);
        check_windows("c_win");
        vs_pulse();
        check("c_frame_done",  int'(bus.frame_done),  1);
        check("c_meas_width",  int'(bus.meas_width),  5);
        check("c_meas_height", int'(bus.meas_height), 4);

        // ---- frame D: enable dropped mid-frame ----
        for (int l = 0; l < 3; l++) line(5);
        for (int p = 0; p < 3; p++) cycle(1'b0, 1'b0, 1'b1);
        check("d_win_valid_before", int'(bus.win_valid), 1);
        bus.enable = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        check("d_win_valid_off", int'(bus.win_valid),   0);
        check("d_win_x_hold",    int'(bus.win_x),       1);
        check("d_win_y_hold",    int'(bus.win_y),       2);
        check("d_meas_w_hold",   int'(bus.meas_width),  5);
        check("d_meas_h_hold",   int'(bus.meas_height), 4);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        bus.enable = 1'b1;
        clear_obs();
        for (int l = 0; l < 3; l++) line(5);
        check("d_idle_no_win",   wx_q.size(), 0);
        check("d_idle_no_start", fs_cnt,      0);
        check("d_idle_meas_w",   int'(bus.meas_width), 5);

        // ---- frame E: async reset mid-line ----
        vs_pulse();
        check("e_frame_start", int'(bus.frame_start), 1);
        check("e_no_done",     int'(bus.frame_done),  0);
        for (int l = 0; l < 3; l++) line(5);
        for (int p = 0; p < 3; p++) cycle(1'b0, 1'b0, 1'b1);
        check("e_win_valid_before", int'(bus.win_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_win_valid", int'(bus.win_valid),   0);
        check("e_rst_win_x",     int'(bus.win_x),       0);
        check("e_rst_win_y",     int'(bus.win_y),       0);
        check("e_rst_meas_w",    int'(bus.meas_width),  0);
        check("e_rst_meas_h",    int'(bus.meas_height), 0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        clear_obs();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 4; l++) line(5);
        check("e_after_rst_no_win",   wx_q.size(), 0);
        check("e_after_rst_no_start", fs_cnt,      0);

        // ---- frame F: 2101-pixel lines overflow MAX_WIDTH ----
        vs_pulse();
        check("f_frame_start", int'(bus.frame_start), 1);
        line(2101);
        check("f_fmt_err", int'(bus.fmt_err), 1);
        line(2101);
        clear_obs();
        line(2101);
        check("f_win_count", wx_q.size(), 2098);
        check("f_max_x",     max_x,       2098);
        check("f_err_sticky", int'(bus.fmt_err), 1);
        vs_pulse();
        check("f_frame_done",  int'(bus.frame_done),  1);
        check("f_meas_width",  int'(bus.meas_width),  2100);
        check("f_meas_height", int'(bus.meas_height), 3);
        check("f_fmt_cleared", int'(bus.fmt_err),     0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Frame/line sequencer for the 3x3 Sobel window path. It watches the same raw hsync/vsync/de that feed the line buffer and tracks input row and column. It flags cycles where the 3x3 window holds nine real image pixels, with the window-centre coordinates. It also measures frame geometry and reports format errors to the control/register side.

Parameters:
MAX_WIDTH, 2100, max active pixels per line (matches line buffer WIDTH)
MAX_HEIGHT, 2100, max active lines per frame
CNT_W, 12, width of coordinate/measurement counters (2^CNT_W > max(MAX_WIDTH, MAX_HEIGHT))

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run control; low forces IDLE
hsync  in  1  raw hsync, same cycle as line buffer input
vsync  in  1  raw vsync; rising edge = frame start
de  in  1  raw data enable
win_valid  out  1  window holds 9 real pixels (aligned to line buffer matrix outputs)
win_x  out  CNT_W  window-centre column
win_y  out  CNT_W  window-centre row
frame_start  out  1  1-cycle pulse on accepted frame start
frame_done  out  1  1-cycle pulse when previous frame's measurements latch
meas_width  out  CNT_W  active width of last completed frame
meas_height  out  CNT_W  active line count of last completed frame
fmt_err  out  1  sticky format error for current frame

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0; vsync/de history regs 0.
- Edge detect: vs_rise = vsync & ~vsync_q; de_fall = ~de & de_q.
- States: IDLE, WAIT_LINE, ACTIVE, BLANK.
  - IDLE: enable & vs_rise -> WAIT_LINE (or ACTIVE if de same cycle); pulse frame_start.
  - WAIT_LINE: de -> ACTIVE, col=1 after first pixel, row=0.
  - ACTIVE: each de cycle col++; de_fall -> BLANK, row++, line width checked.
  - BLANK: de -> ACTIVE, col restarts (first pixel col=0).
  - Any non-IDLE state, vs_rise: latch meas_width (first line's width) and meas_height (row count, including a line still in ACTIVE). Pulse frame_done only if ≥1 line seen. Then frame_start, clear fmt_err and counters, go to WAIT_LINE (ACTIVE if de same cycle).
  - enable low: IDLE next cycle; win_valid 0; meas_* and fmt_err hold.
- Simultaneous vs_rise & de: frame start wins; that de pixel is (row 0, col 0).
- Window: input pixel at (r,c) on cycle t. At t+1 the line buffer centre holds (r-1,c-1). Registered outputs at t+1: win_valid = de & r≥2 & c≥2; win_x = c-1; win_y = r-1. Output grid is (H-2)x(W-2). win_x/win_y hold last value when win_valid is 0.
- fmt_err set (sticky to next frame_start) when: a line's width ≠ first line width; col reaches MAX_WIDTH (col saturates, win_valid forced 0 for rest of line); row reaches MAX_HEIGHT (row saturates, win_valid 0 until next frame).
- hsync is used only to confirm line boundaries. de_fall without a prior hsync rising edge in the line is not an error.
- Counters unsigned, saturating, never wrap.

Optional Feature:
SOBEL_WCTRL_STATS_EN: defined adds output frame_cnt (16 bit), incremented on each frame_done and wrapping at 0xFFFF->0. Also adds err_cnt (16 bit, saturating), incremented on each fmt_err 0->1 transition. Both are reset by rst only. Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package sobel_pkg: state encoding localparams (IDLE=0, WAIT_LINE=1, ACTIVE=2, BLANK=3), default MAX_WIDTH/MAX_HEIGHT/CNT_W, shared with line buffer instantiation.
- One natural sub-module: sobel_edge_det (registered rising/falling edge detector, async reset), instantiated for vsync, hsync, de.

Test Plan:
- 5x4 frame (de 5 cycles, 3 blank, 4 lines), then vs_rise -> win_valid exactly 6 cycles, (x,y) ∈ {1..3}x{1..2}. Next vs_rise gives frame_done, meas_width=5, meas_height=4, fmt_err=0.
- Line 2 width 4 in 5-wide frame -> fmt_err=1 after that line's de_fall; next frame_start clears it.
- vs_rise and de high same cycle -> frame_start=1 and that pixel counted as col 0. With 5x4 the win_valid count is still 6.
- Reset asserted mid-line (async, between clock edges) -> outputs 0 immediately. After release, no win_valid until a new vs_rise.
- enable dropped mid-frame -> win_valid 0 next cycle, meas_* unchanged. Re-enable without vs_rise -> stays IDLE.
- 2101-pixel line with MAX_WIDTH=2100 -> fmt_err=1, col saturates at 2100, no win_valid past x=2098.
